// File: rtl/funct_gen_pipe_pkg.sv
// Shared opcode/funct constants and small helpers for the registered ALU function generator.
package funct_gen_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_SLL     = 6'h00;
  localparam logic [5:0] FUNCT_SRL     = 6'h02;
  localparam logic [5:0] FUNCT_SRA     = 6'h03;
  localparam logic [5:0] FUNCT_SLLV    = 6'h04;
  localparam logic [5:0] FUNCT_SRLV    = 6'h06;
  localparam logic [5:0] FUNCT_SRAV    = 6'h07;
  localparam logic [5:0] FUNCT_JR      = 6'h08;
  localparam logic [5:0] FUNCT_JALR    = 6'h09;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam logic [5:0] FUNCT_BREAK   = 6'h0D;
  localparam logic [5:0] FUNCT_MFHI    = 6'h10;
  localparam logic [5:0] FUNCT_MTHI    = 6'h11;
  localparam logic [5:0] FUNCT_MFLO    = 6'h12;
  localparam logic [5:0] FUNCT_MTLO    = 6'h13;
  localparam logic [5:0] FUNCT_MULT    = 6'h18;
  localparam logic [5:0] FUNCT_MULTU   = 6'h19;
  localparam logic [5:0] FUNCT_DIV     = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
  localparam logic [5:0] FUNCT_ADD     = 6'h20;
  localparam logic [5:0] FUNCT_ADDU    = 6'h21;
  localparam logic [5:0] FUNCT_SUB     = 6'h22;
  localparam logic [5:0] FUNCT_SUBU    = 6'h23;
  localparam logic [5:0] FUNCT_AND     = 6'h24;
  localparam logic [5:0] FUNCT_OR      = 6'h25;
  localparam logic [5:0] FUNCT_XOR     = 6'h26;
  localparam logic [5:0] FUNCT_NOR     = 6'h27;
  localparam logic [5:0] FUNCT_SLT     = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU    = 6'h2B;
  localparam logic [5:0] FUNCT_NOP     = FUNCT_SLL;

  // Width of the MDU busy countdown for a given longest operation.
  function automatic int mdu_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic logic special_defined(input logic [5:0] f);
    case (f)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV,
      FUNCT_JR, FUNCT_JALR, FUNCT_SYSCALL, FUNCT_BREAK,
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
      FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
      FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
      FUNCT_SLT, FUNCT_SLTU: special_defined = 1'b1;
      default:               special_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/funct_gen_pipe_if.sv
// Decode-side and EX-side handshake bundle of the function generator, plus flush and MDU status.
interface funct_gen_pipe_if #(
  parameter int LANES = 2
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [LANES-1:0]   in_lane_v;
  logic [LANES*6-1:0] in_op;
  logic [LANES*6-1:0] in_funct;
  logic               out_valid;
  logic               out_ready;
  logic [LANES-1:0]   out_lane_v;
  logic [LANES*6-1:0] out_funct;
  logic [LANES-1:0]   out_illegal;
  logic               mdu_busy;

  modport slave (
    input  flush, in_valid, in_lane_v, in_op, in_funct, out_ready,
    output in_ready, out_valid, out_lane_v, out_funct, out_illegal, mdu_busy
  );

  modport master (
    output flush, in_valid, in_lane_v, in_op, in_funct, out_ready,
    input  in_ready, out_valid, out_lane_v, out_funct, out_illegal, mdu_busy
  );
endinterface

// File: rtl/funct_gen_pipe_map.sv
// Per-lane combinational op/funct decoder: ALU funct, illegal flag and MDU class.
// Illegal-opcode flagging is built only when FUNCT_GEN_ILLEGAL_EN is defined.
module funct_gen_pipe_map
  import funct_gen_pipe_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [5:0] o_funct,
  output logic       o_illegal,
  output logic       o_start,
  output logic       o_hilo,
  output logic       o_div
);
  logic [5:0] w_raw_funct;
  logic       w_special;

  always_comb begin
    w_raw_funct = FUNCT_NOP;
    case (i_op)
      OP_SPECIAL:                 w_raw_funct = i_funct;
      OP_SLTI:                    w_raw_funct = FUNCT_SLT;
      OP_SLTIU:                   w_raw_funct = FUNCT_SLTU;
      OP_ANDI:                    w_raw_funct = FUNCT_AND;
      OP_ORI, OP_LUI, OP_JAL:     w_raw_funct = FUNCT_OR;
      OP_XORI:                    w_raw_funct = FUNCT_XOR;
      OP_ADDI:                    w_raw_funct = FUNCT_ADD;
      OP_ADDIU, OP_LB, OP_LBU, OP_LH, OP_LHU,
      OP_LW, OP_SB, OP_SH, OP_SW: w_raw_funct = FUNCT_ADDU;
      default:                    w_raw_funct = FUNCT_NOP;
    endcase
  end

  assign w_special = (i_op == OP_SPECIAL);
  assign o_start   = w_special &
                     (i_funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
  assign o_hilo    = w_special &
                     (i_funct inside {FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO});
  assign o_div     = w_special & (i_funct inside {FUNCT_DIV, FUNCT_DIVU});

`ifdef FUNCT_GEN_ILLEGAL_EN
  logic w_bad;
  // Every mapped non-SPECIAL opcode yields a non-NOP funct, so NOP marks "unmapped".
  assign w_bad     = w_special ? !special_defined(i_funct) : (w_raw_funct == FUNCT_NOP);
  assign o_funct   = w_bad ? FUNCT_NOP : w_raw_funct;
  assign o_illegal = w_bad;
`else
  assign o_funct   = w_raw_funct;
  assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/funct_gen_pipe.sv
// Registered multi-lane ALU function generator with MDU interlock and one-entry skid.
// Optional illegal-opcode reporting via FUNCT_GEN_ILLEGAL_EN (see funct_gen_pipe_map).
module funct_gen_pipe
  import funct_gen_pipe_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input logic              i_clk,
  input logic              i_rst,
  funct_gen_pipe_if.slave  bus
);
  localparam int CNT_W = mdu_cnt_w(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  logic [5:0]         w_lane_funct [LANES];
  logic [LANES-1:0]   w_lane_ill, w_lane_start, w_lane_hilo, w_lane_div, w_lane_mdu;

  logic               r_out_valid;
  logic [LANES-1:0]   r_out_lane_v, r_out_ill;
  logic [LANES*6-1:0] r_out_funct;
  logic               r_skid_v, r_skid_ill, r_skid_start, r_skid_hilo, r_skid_div;
  logic [5:0]         r_skid_funct;
  logic [CNT_W-1:0]   r_mdu_cnt;

  logic               w_cnt_nz, w_out_free, w_in_haz, w_skid_haz;
  logic               w_in_ready, w_accept, w_skid_issue, w_split;
  logic               w_split_ill, w_split_start, w_split_hilo, w_split_div;
  logic [5:0]         w_split_funct;
  logic [LANES-1:0]   w_nxt_lane_v, w_nxt_ill;
  logic [LANES*6-1:0] w_nxt_funct;
  logic               w_issue_start, w_issue_div;

  for (genvar g = 0; g < LANES; g++) begin : g_map
    funct_gen_pipe_map u_map (
      .i_op      (bus.in_op[6*g +: 6]),
      .i_funct   (bus.in_funct[6*g +: 6]),
      .o_funct   (w_lane_funct[g]),
      .o_illegal (w_lane_ill[g]),
      .o_start   (w_lane_start[g]),
      .o_hilo    (w_lane_hilo[g]),
      .o_div     (w_lane_div[g])
    );
  end

  assign w_lane_mdu = w_lane_start | w_lane_hilo;

  // Lane 1 must not see HI/LO or start the MDU in the same bundle as a lane-0 MDU start.
  if (LANES > 1) begin : g_split
    assign w_split       = bus.in_lane_v[0] & w_lane_start[0] &
                           bus.in_lane_v[1] & w_lane_mdu[1];
    assign w_split_funct = w_lane_funct[1];
    assign w_split_ill   = w_lane_ill[1];
    assign w_split_start = w_lane_start[1];
    assign w_split_hilo  = w_lane_hilo[1];
    assign w_split_div   = w_lane_div[1];
  end else begin : g_nosplit
    assign w_split       = 1'b0;
    assign w_split_funct = FUNCT_NOP;
    assign w_split_ill   = 1'b0;
    assign w_split_start = 1'b0;
    assign w_split_hilo  = 1'b0;
    assign w_split_div   = 1'b0;
  end

  assign w_cnt_nz     = (r_mdu_cnt != '0);
  assign w_out_free   = !r_out_valid | bus.out_ready;
  assign w_in_haz     = w_cnt_nz & |(bus.in_lane_v & w_lane_mdu);
  assign w_skid_haz   = w_cnt_nz & r_skid_v & (r_skid_start | r_skid_hilo);
  assign w_in_ready   = i_rst & !bus.flush & w_out_free & !r_skid_v & !w_in_haz & !w_skid_haz;
  assign w_accept     = bus.in_valid & w_in_ready;
  assign w_skid_issue = i_rst & r_skid_v & w_out_free & !bus.flush & !w_skid_haz;

  always_comb begin
    w_nxt_lane_v  = '0;
    w_nxt_ill     = '0;
    w_nxt_funct   = {LANES{FUNCT_NOP}};
    w_issue_start = 1'b0;
    w_issue_div   = 1'b0;
    if (w_skid_issue) begin
      w_nxt_lane_v[0]  = 1'b1;
      w_nxt_funct[5:0] = r_skid_funct;
      w_nxt_ill[0]     = r_skid_ill;
      w_issue_start    = r_skid_start;
      w_issue_div      = r_skid_start & r_skid_div;
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.in_lane_v[i] && !(w_split && i == 1)) begin
          w_nxt_lane_v[i]      = 1'b1;
          w_nxt_funct[6*i +: 6] = w_lane_funct[i];
          w_nxt_ill[i]         = w_lane_ill[i];
          w_issue_start        = w_issue_start | w_lane_start[i];
          w_issue_div          = w_issue_div | (w_lane_start[i] & w_lane_div[i]);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_lane_v <= '0;
      r_out_funct  <= {LANES{FUNCT_NOP}};
      r_out_ill    <= '0;
    end else if (bus.flush) begin
      r_out_valid  <= 1'b0;
      r_out_lane_v <= '0;
    end else if (w_out_free) begin
      r_out_valid  <= w_accept | w_skid_issue;
      r_out_lane_v <= w_nxt_lane_v;
      r_out_funct  <= w_nxt_funct;
      r_out_ill    <= w_nxt_ill;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || bus.flush) begin
      r_skid_v     <= 1'b0;
      r_skid_funct <= FUNCT_NOP;
      r_skid_ill   <= 1'b0;
      r_skid_start <= 1'b0;
      r_skid_hilo  <= 1'b0;
      r_skid_div   <= 1'b0;
    end else if (w_accept && w_split) begin
      r_skid_v     <= 1'b1;
      r_skid_funct <= w_split_funct;
      r_skid_ill   <= w_split_ill;
      r_skid_start <= w_split_start;
      r_skid_hilo  <= w_split_hilo;
      r_skid_div   <= w_split_div;
    end else if (w_skid_issue) begin
      r_skid_v     <= 1'b0;
    end
  end

  // Flush is not a reset for the MDU: a started divide keeps counting down.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mdu_cnt <= '0;
    end else if (w_issue_start) begin
      r_mdu_cnt <= w_issue_div ? DIV_LOAD : MUL_LOAD;
    end else if (w_cnt_nz) begin
      r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_lane_v  = r_out_lane_v;
  assign bus.out_funct   = r_out_funct;
  assign bus.out_illegal = r_out_ill;
  assign bus.mdu_busy    = w_cnt_nz;

endmodule

// File: tb/tb_funct_gen_pipe.sv
// Bench for funct_gen_pipe: directed scenarios then random traffic against a cycle model.
module tb_funct_gen_pipe;
  localparam int MUL_C = 4;
  localparam int DIV_C = 32;
`ifdef FUNCT_GEN_ILLEGAL_EN
  localparam bit EXP_ILL = 1'b1;
`else
  localparam bit EXP_ILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  funct_gen_pipe_if #(.LANES(2)) bus ();

  funct_gen_pipe #(.LANES(2), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state: output bundle, pending skid instruction (raw op/funct), MDU cycles left
  bit         m_ov, m_sv;
  bit [1:0]   m_lv, m_il;
  logic [5:0] m_fn0, m_fn1, m_sop, m_sfn;
  int         m_cnt;
  bit         dut_acc;

  function automatic bit sp_ok(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D,
                     6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                     6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'h00, 6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic bit ref_ill(input logic [5:0] op, input logic [5:0] fn);
`ifdef FUNCT_GEN_ILLEGAL_EN
    return !op_known(op) || (op == 6'h00 && !sp_ok(fn));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [5:0] ref_fn(input logic [5:0] op, input logic [5:0] fn);
    logic [5:0] r;
    case (op)
      6'h00:                      r = fn;
      6'h0A:                      r = 6'h2A;
      6'h0B:                      r = 6'h2B;
      6'h0C:                      r = 6'h24;
      6'h0D, 6'h0F, 6'h03:        r = 6'h25;
      6'h0E:                      r = 6'h26;
      6'h08:                      r = 6'h20;
      6'h09, 6'h20, 6'h21, 6'h23, 6'h24,
      6'h25, 6'h28, 6'h29, 6'h2B: r = 6'h21;
      default:                    r = 6'h00;
    endcase
    if (ref_ill(op, fn)) r = 6'h00;
    return r;
  endfunction

  function automatic bit is_start(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h00 && fn inside {6'h18, 6'h19, 6'h1A, 6'h1B};
  endfunction
  function automatic bit is_div(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h00 && fn inside {6'h1A, 6'h1B};
  endfunction
  function automatic bit is_mdu(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h00 && fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit [1:0] lv, input logic [5:0] op0, input logic [5:0] fn0,
                       input logic [5:0] op1, input logic [5:0] fn1, input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_lane_v = lv;
    bus.in_op     = {op1, op0};
    bus.in_funct  = {fn1, fn0};
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: check pre-edge ready/busy, advance the model, check registered outputs.
  task automatic cycle();
    logic [5:0] op0, fn0, op1, fn1, n_fn0, n_fn1, n_sop, n_sfn;
    bit [1:0]   lv, n_lv, n_il;
    bit         busy, haz, free, exp_rdy, acc, skid_go, s_mdu, split, n_ov, n_sv;
    int         n_cnt;
    #1;
    op0 = bus.in_op[5:0];    fn0 = bus.in_funct[5:0];
    op1 = bus.in_op[11:6];   fn1 = bus.in_funct[11:6];
    lv  = bus.in_lane_v;
    busy    = m_cnt > 0;
    s_mdu   = m_sv && is_mdu(m_sop, m_sfn);
    haz     = busy && ((lv[0] && is_mdu(op0, fn0)) || (lv[1] && is_mdu(op1, fn1)) || s_mdu);
    free    = !m_ov || bus.out_ready;
    exp_rdy = rst && !bus.flush && free && !m_sv && !haz;
    acc     = bus.in_valid && exp_rdy;
    skid_go = rst && m_sv && free && !bus.flush && !(busy && s_mdu);
    check("in_ready", bus.in_ready, exp_rdy);
    check("mdu_busy", bus.mdu_busy, busy);
    dut_acc = bus.in_valid && bus.in_ready;

    n_ov = m_ov; n_lv = m_lv; n_il = m_il; n_fn0 = m_fn0; n_fn1 = m_fn1;
    n_sv = m_sv; n_sop = m_sop; n_sfn = m_sfn;
    n_cnt = busy ? m_cnt - 1 : 0;
    if (!rst) begin
      n_ov = 0; n_lv = 0; n_il = 0; n_fn0 = 6'h00; n_fn1 = 6'h00; n_sv = 0; n_cnt = 0;
    end else if (bus.flush) begin
      n_ov = 0; n_lv = 0; n_sv = 0;
    end else if (free) begin
      n_lv = 0; n_il = 0; n_fn0 = 6'h00; n_fn1 = 6'h00; n_ov = skid_go || acc;
      if (skid_go) begin
        n_lv[0] = 1; n_fn0 = ref_fn(m_sop, m_sfn); n_il[0] = ref_ill(m_sop, m_sfn);
        if (is_start(m_sop, m_sfn)) n_cnt = is_div(m_sop, m_sfn) ? DIV_C : MUL_C;
        n_sv = 0;
      end else if (acc) begin
        split = lv[0] && is_start(op0, fn0) && lv[1] && is_mdu(op1, fn1);
        if (lv[0]) begin
          n_lv[0] = 1; n_fn0 = ref_fn(op0, fn0); n_il[0] = ref_ill(op0, fn0);
          if (is_start(op0, fn0)) n_cnt = is_div(op0, fn0) ? DIV_C : MUL_C;
        end
        if (lv[1] && !split) begin
          n_lv[1] = 1; n_fn1 = ref_fn(op1, fn1); n_il[1] = ref_ill(op1, fn1);
          if (is_start(op1, fn1)) n_cnt = is_div(op1, fn1) ? DIV_C : MUL_C;
        end
        if (split) begin
          n_sv = 1; n_sop = op1; n_sfn = fn1;
        end
      end
    end

    @(posedge clk);
    #1;
    m_ov = n_ov; m_lv = n_lv; m_il = n_il; m_fn0 = n_fn0; m_fn1 = n_fn1;
    m_sv = n_sv; m_sop = n_sop; m_sfn = n_sfn; m_cnt = n_cnt;
    check("out_valid", bus.out_valid, m_ov);
    check("out_lane_v", bus.out_lane_v, m_lv);
    check("out_funct", bus.out_funct, {m_fn1, m_fn0});
    check("out_illegal", bus.out_illegal, m_il);
    @(negedge clk);
  endtask

  task automatic pick(output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] ops [18];
    logic [5:0] mfn [10];
    int r;
    ops = '{6'h00, 6'h03, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    mfn = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h21, 6'h25};
    r  = $urandom_range(0, 9);
    fn = 6'($urandom_range(0, 63));
    if (r <= 2) begin
      op = 6'h00; fn = mfn[$urandom_range(0, 9)];
    end else if (r == 3) begin
      op = 6'h00;
    end else if (r == 4) begin
      op = 6'($urandom_range(0, 63));
    end else begin
      op = ops[$urandom_range(0, 17)];
    end
  endtask

  initial begin
    int         n;
    logic [5:0] a0, b0, a1, b1;

    rst = 1'b0;
    drive(0, 2'b00, 6'h00, 6'h00, 6'h00, 6'h00, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_ov = 0; m_lv = 0; m_il = 0; m_fn0 = 6'h00; m_fn1 = 6'h00; m_sv = 0; m_cnt = 0;
    m_sop = 6'h00; m_sfn = 6'h00;
    cycle();
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_funct", bus.out_funct, 12'h000);
    rst = 1'b1;

    // T1: lane0 ORI, lane1 ADDIU -> {ADDU, OR}
    drive(1, 2'b11, 6'h0D, 6'h00, 6'h09, 6'h00, 1, 0);
    cycle();
    check("t1_funct", bus.out_funct, {6'h21, 6'h25});
    check("t1_lane_v", bus.out_lane_v, 2'b11);

    // T2: DIV, then MFLO waits the 32 busy cycles and goes on the 33rd
    drive(1, 2'b01, 6'h00, 6'h1A, 6'h00, 6'h00, 1, 0);
    cycle();
    drive(1, 2'b01, 6'h00, 6'h12, 6'h00, 6'h00, 1, 0);
    n = 0;
    cycle();
    while (!dut_acc && n < 40) begin
      n++;
      cycle();
    end
    check("t2_stall_cycles", n, 32);
    check("t2_mflo_out", bus.out_funct[5:0], 6'h12);

    // T3: {MULT, MFHI}: MULT alone, MFHI re-issued from skid once 4 busy cycles elapse
    drive(1, 2'b11, 6'h00, 6'h18, 6'h00, 6'h10, 1, 0);
    cycle();
    check("t3_lane_v", bus.out_lane_v, 2'b01);
    check("t3_mult", bus.out_funct[5:0], 6'h18);
    drive(0, 2'b00, 6'h00, 6'h00, 6'h00, 6'h00, 1, 0);
    n = 0;
    do begin
      n++;
      cycle();
    end while (!bus.out_valid && n < 20);
    check("t3_skid_edges", n, MUL_C + 1);
    check("t3_skid_funct", bus.out_funct[5:0], 6'h10);
    check("t3_skid_lane_v", bus.out_lane_v, 2'b01);

    // T4: EX back-pressure holds the output and refuses the next bundle
    drive(0, 2'b00, 6'h00, 6'h00, 6'h00, 6'h00, 1, 0);
    cycle();
    drive(1, 2'b11, 6'h0E, 6'h00, 6'h0A, 6'h00, 0, 0);
    cycle();
    drive(1, 2'b11, 6'h0C, 6'h00, 6'h23, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_hold_funct", bus.out_funct, {6'h2A, 6'h26});
      check("t4_no_accept", dut_acc, 1'b0);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("t4_next_funct", bus.out_funct, {6'h21, 6'h24});

    // T5: flush while a divide runs and the skid holds MFLO
    drive(1, 2'b11, 6'h00, 6'h1A, 6'h00, 6'h12, 1, 0);
    cycle();
    drive(0, 2'b00, 6'h00, 6'h00, 6'h00, 6'h00, 1, 0);
    cycle();
    cycle();
    bus.flush = 1'b1;
    cycle();
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_mdu_busy", bus.mdu_busy, 1'b1);
    drive(1, 2'b01, 6'h08, 6'h00, 6'h00, 6'h00, 1, 0);
    cycle();
    check("t5_skid_empty_accept", dut_acc, 1'b1);
    drive(0, 2'b00, 6'h00, 6'h00, 6'h00, 6'h00, 1, 0);
    repeat (DIV_C) cycle();

    // flush coinciding with a MULT: no accept, counter stays idle
    drive(1, 2'b01, 6'h00, 6'h18, 6'h00, 6'h00, 1, 1);
    cycle();
    check("flush_start_busy", bus.mdu_busy, 1'b0);

    // T6: unmapped opcode 0x3F
    drive(1, 2'b01, 6'h3F, 6'h00, 6'h00, 6'h00, 1, 0);
    cycle();
    check("t6_illegal", bus.out_illegal[0], EXP_ILL);
    check("t6_funct_nop", bus.out_funct[5:0], 6'h00);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      pick(a0, b0);
      pick(a1, b1);
      rst = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a0, b0, a1, b1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
